// File: rtl/time_set_ctrl.sv
// Three-button time-setting controller: debounce, edit FSM and load hold for the time-of-day counter.
// Auto-repeat on a held up/down button is built only when TIME_SET_AUTO_REPEAT_EN is defined.
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES  = 1_000_000,
  parameter int LOAD_HOLD_CYCLES = 100_000_000,
  parameter int REPEAT_DELAY     = 50_000_000,
  parameter int REPEAT_CYCLES    = 20_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [7:0] cur_hours,
  input  logic [7:0] cur_minutes,
  input  logic [7:0] cur_seconds,
  output logic [7:0] newHours,
  output logic [7:0] newMinutes,
  output logic [7:0] newSeconds,
  output logic       set_active,
  output logic [1:0] edit_field
);
  typedef enum logic [2:0] {RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT} state_t;

  localparam int DW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW     = $clog2(LOAD_HOLD_CYCLES + 1);
  localparam int B_MODE = 0;
  localparam int B_UP   = 1;
  localparam int B_DOWN = 2;

  logic [2:0]    raw, sync1, sync2, level, level_d, press;
  logic [DW-1:0] db_cnt [3];

  assign raw = {btn_down, btn_up, btn_mode};

  // The level flips only after the synchronized input has disagreed with it for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement in between restarts the count.
  always_ff @(posedge CLK100MHZ) begin
    if (!reset_n) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let sync1->sync2->level behave as a real shift chain.
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [7:0]    hours_d, minutes_d, seconds_d;
  logic          mode_evt, up_req, down_req;

  assign mode_evt = press[B_MODE];

`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_first, rep_held, rep_fire;

  assign rep_held = (level[B_UP] ^ level[B_DOWN]) &&
                    (state_q == EDIT_H || state_q == EDIT_M || state_q == EDIT_S);
  assign rep_fire = rep_held && !(|press) &&
                    (rep_first ? (rep_cnt == RW'(REPEAT_DELAY - 1))
                               : (rep_cnt == RW'(REPEAT_CYCLES - 1)));

  always_ff @(posedge CLK100MHZ) begin
    if (!reset_n || (|press) || !rep_held) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  assign up_req   = press[B_UP]   | (rep_fire & level[B_UP]);
  assign down_req = press[B_DOWN] | (rep_fire & level[B_DOWN]);
`else
  logic unused_repeat;

  assign up_req        = press[B_UP];
  assign down_req      = press[B_DOWN];
  assign unused_repeat = ^{REPEAT_DELAY, REPEAT_CYCLES};
`endif

  function automatic logic [7:0] step(input logic [7:0] v, input logic [7:0] top,
                                      input logic inc, input logic dec);
    if (inc && !dec) return (v == top) ? 8'd0 : v + 8'd1;
    if (dec && !inc) return (v == 8'd0) ? top : v - 8'd1;
    return v;
  endfunction

  function automatic logic [7:0] clamp(input logic [7:0] v, input logic [7:0] range);
    return (v < range) ? v : 8'd0;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first, so no branch can infer a latch.
    state_d   = state_q;
    hours_d   = newHours;
    minutes_d = newMinutes;
    seconds_d = newSeconds;
    hold_d    = '0;
    unique case (state_q)
      RUN: if (mode_evt) begin
        state_d   = EDIT_H;
        hours_d   = clamp(cur_hours, 8'd24);
        minutes_d = clamp(cur_minutes, 8'd60);
        seconds_d = clamp(cur_seconds, 8'd60);
      end
      EDIT_H: if (mode_evt) state_d = EDIT_M;
              else hours_d = step(newHours, 8'd23, up_req, down_req);
      EDIT_M: if (mode_evt) state_d = EDIT_S;
              else minutes_d = step(newMinutes, 8'd59, up_req, down_req);
      EDIT_S: if (mode_evt) state_d = COMMIT;
              else seconds_d = step(newSeconds, 8'd59, up_req, down_req);
      COMMIT: if (hold_q == HW'(LOAD_HOLD_CYCLES - 1)) state_d = RUN;
              else hold_d = hold_q + 1'b1;
      default: state_d = RUN;
    endcase
  end

  // Outputs are decoded from the next state so they change together with it.
  always_ff @(posedge CLK100MHZ) begin
    if (!reset_n) begin
      state_q    <= RUN;
      hold_q     <= '0;
      newHours   <= 8'd0;
      newMinutes <= 8'd0;
      newSeconds <= 8'd0;
      set_active <= 1'b0;
      edit_field <= 2'd0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      newHours   <= hours_d;
      newMinutes <= minutes_d;
      newSeconds <= seconds_d;
      set_active <= (state_d != RUN);
      case (state_d)
        EDIT_H:  edit_field <= 2'd1;
        EDIT_M:  edit_field <= 2'd2;
        EDIT_S:  edit_field <= 2'd3;
        default: edit_field <= 2'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: timestamped scoreboard fed by a time-aware behavioural model,
// drained by an independent monitor that also flags any output change nobody predicted.
module tb_time_set_ctrl;
  localparam int D    = 4;
  localparam int L    = 10;
  localparam int RD   = 8;
  localparam int RC   = 3;
  localparam int LAT  = D + 4;  // raw edge to visible output change
  localparam int HOLD = 14;     // long hold used for the auto-repeat case

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_mode, btn_up, btn_down;
  logic [7:0] cur_hours, cur_minutes, cur_seconds;
  logic [7:0] newHours, newMinutes, newSeconds;
  logic       set_active;
  logic [1:0] edit_field;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .LOAD_HOLD_CYCLES(L),
    .REPEAT_DELAY    (RD),
    .REPEAT_CYCLES   (RC)
  ) dut (
    .CLK100MHZ  (clk),
    .reset_n    (reset_n),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .cur_hours  (cur_hours),
    .cur_minutes(cur_minutes),
    .cur_seconds(cur_seconds),
    .newHours   (newHours),
    .newMinutes (newMinutes),
    .newSeconds (newSeconds),
    .set_active (set_active),
    .edit_field (edit_field)
  );

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic       sa;
    logic [1:0] ef;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t exp;
    string tag;
  } exp_t;

  exp_t  sb[$];
  int    edges = 0;
  int    vectors = 0;
  int    miscompares = 0;
  snap_t act;

  assign act = {newHours, newMinutes, newSeconds, set_active, edit_field};

  always @(posedge clk) edges <= edges + 1;

  // Reference model: 0 run, 1..3 editing that field, 4 commit (until m_run_at).
  int m_state, m_h, m_m, m_s, m_run_at;

  function automatic snap_t model_snap();
    snap_t s;
    s.h  = 8'(m_h);
    s.m  = 8'(m_m);
    s.s  = 8'(m_s);
    s.sa = (m_state != 0);
    s.ef = (m_state >= 1 && m_state <= 3) ? 2'(m_state) : 2'd0;
    return s;
  endfunction

  task automatic expect_at(input int cyc, input string tag);
    exp_t e;
    int   i;
    e.cyc = cyc;
    e.exp = model_snap();
    e.tag = tag;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > cyc) i--;
    sb.insert(i, e);
  endtask

  function automatic int wrap(input int v, input int d, input int range);
    return (v + d + range) % range;
  endfunction

  // Debounced events seen at cycle ev; their effect is visible at ev+1.
  task automatic apply(input bit mode, input bit up, input bit dn, input int ev, input string tag);
    int d;
    bit to_commit;
    to_commit = 0;
    if (m_state == 4 && ev >= m_run_at) m_state = 0;
    if (m_state != 4) begin
      if (mode) begin
        if (m_state == 0) begin
          m_h = (cur_hours   < 24) ? int'(cur_hours)   : 0;
          m_m = (cur_minutes < 60) ? int'(cur_minutes) : 0;
          m_s = (cur_seconds < 60) ? int'(cur_seconds) : 0;
        end
        m_state++;
        to_commit = (m_state == 4);
      end else if (m_state != 0 && up != dn) begin
        d = up ? 1 : -1;
        case (m_state)
          1:       m_h = wrap(m_h, d, 24);
          2:       m_m = wrap(m_m, d, 60);
          default: m_s = wrap(m_s, d, 60);
        endcase
      end
    end
    expect_at(ev + 1, tag);
    if (to_commit) begin
      m_run_at = ev + 1 + L;
      expect_at(ev + L, {tag, "_hold_last"});
      m_state = 0;
      expect_at(ev + 1 + L, {tag, "_run"});
      m_state = 4;
    end
  endtask

  task automatic check(input string tag, input int cyc, input snap_t got, input snap_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0d:%0d:%0d sa=%b ef=%0d, expected %0d:%0d:%0d sa=%b ef=%0d",
               tag, cyc, got.h, got.m, got.s, got.sa, got.ef,
               want.h, want.m, want.s, want.sa, want.ef);
    end
  endtask

  initial begin : monitor
    snap_t prev;
    bit    armed;
    bit    hit;
    exp_t  e;
    armed = 0;
    prev  = '0;
    forever begin
      @(negedge clk);
      hit = 0;
      while (sb.size() > 0 && sb[0].cyc <= edges) begin
        e     = sb.pop_front();
        hit   = 1;
        armed = 1;
        if (e.cyc != edges) begin
          miscompares++;
          $display("FAIL %s: due at cycle %0d, reached at %0d", e.tag, e.cyc, edges);
        end else begin
          check(e.tag, edges, act, e.exp);
        end
      end
      if (!hit && armed && act !== prev) begin
        miscompares++;
        $display("FAIL unexpected_change cycle %0d: got %0d:%0d:%0d sa=%b ef=%0d, expected unchanged %0d:%0d:%0d sa=%b ef=%0d",
                 edges, act.h, act.m, act.s, act.sa, act.ef,
                 prev.h, prev.m, prev.s, prev.sa, prev.ef);
      end
      prev = act;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [2:0] b);
    {btn_down, btn_up, btn_mode} = b;
  endtask

  // b: bit0 mode, bit1 up, bit2 down; all pressed on the same cycle.
  task automatic press(input logic [2:0] b, input int hold, input string tag);
    int k;
    tick(1);
    drive(b);
    k = edges;
    apply(b[0], b[1], b[2], k + LAT - 1, tag);
    tick(hold);
    drive(3'b000);
    tick(D + 8);
  endtask

  function automatic logic [2:0] rand_step();
    case ($urandom_range(0, 2))
      0:       return 3'b010;
      1:       return 3'b100;
      default: return 3'b110;
    endcase
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    reset_n = 1'b0;
    drive(3'b000);
    cur_hours = 8'd0; cur_minutes = 8'd0; cur_seconds = 8'd0;
    m_state = 0; m_h = 0; m_m = 0; m_s = 0; m_run_at = 0;
    @(posedge clk);
    #1;
    expect_at(edges, "reset_state");
    tick(2);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      btn_mode = ((i / 2) % 2 == 0);
      tick(1);
    end
    btn_mode = 1'b0;
    tick(D + 8);
    expect_at(edges, "bounce_ignored");

    cur_hours = 8'd12; cur_minutes = 8'd34; cur_seconds = 8'd56;
    tick(1);
    drive(3'b001);
    k = edges;
    expect_at(k + LAT - 1, "entry_not_yet");
    apply(1, 0, 0, k + LAT - 1, "entry");
    tick(6);
    drive(3'b000);
    tick(D + 8);

    for (int f = 0; f < 3; f++) begin
      repeat ($urandom_range(1, 4)) press(rand_step(), 6, "edit_step");
      if (f < 2) press(3'b001, 6, "advance");
    end

    // Third mode enters COMMIT; an up press lands while the hold is running.
    tick(1);
    drive(3'b001);
    k = edges;
    apply(1, 0, 0, k + LAT - 1, "commit");
    tick(2);
    drive(3'b011);
    apply(0, 1, 0, k + 2 + LAT - 1, "commit_up_ignored");
    tick(4);
    drive(3'b010);
    tick(2);
    drive(3'b000);
    tick(D + 12);

    cur_hours = 8'd23; cur_minutes = 8'd58; cur_seconds = 8'd0;
    press(3'b001, 6, "entry_23_58_00");
    press(3'b010, 6, "hours_wrap_up");
    press(3'b100, 6, "hours_wrap_down");
    press(3'b001, 6, "to_minutes");
    press(3'b110, 6, "up_down_same_cycle");

    tick(1);
    drive(3'b010);
    k = edges;
    apply(0, 1, 0, k + LAT - 1, "hold_up_first");
`ifdef TIME_SET_AUTO_REPEAT_EN
    for (int t = RD; t + LAT - 1 < HOLD + D + 2; t += RC)
      apply(0, 1, 0, k + LAT - 1 + t, "auto_repeat");
`endif
    tick(HOLD);
    drive(3'b000);
    tick(D + 8);

    press(3'b011, 6, "mode_with_up");
    press(3'b100, 6, "seconds_wrap_down");
    press(3'b001, 6, "commit2");

    cur_hours   = 8'($urandom_range(24, 255));
    cur_minutes = 8'($urandom_range(60, 255));
    cur_seconds = 8'($urandom_range(0, 59));
    press(3'b001, 6, "clamp_entry");
    press(3'b001, 6, "to_minutes_again");

    tick(1);
    reset_n = 1'b0;
    k = edges;
    m_state = 0; m_h = 0; m_m = 0; m_s = 0;
    expect_at(k + 1, "reset_mid_edit");
    tick(1);
    reset_n = 1'b1;
    press(3'b010, 6, "up_in_run");

    for (int r = 0; r < 4; r++) begin
      cur_hours   = 8'($urandom_range(0, 27));
      cur_minutes = 8'($urandom_range(0, 63));
      cur_seconds = 8'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) press(rand_step(), 6, "run_ignored");
      press(3'b001, 6, "rand_entry");
      for (int f = 0; f < 3; f++) begin
        repeat ($urandom_range(0, 3)) press(rand_step(), 6, "rand_step");
        press(3'b001 | 3'(3'($urandom_range(0, 3)) << 1), 6, "rand_advance");
      end
    end

    tick(D + 8);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
